gpio_uart_tx: RTL and testbench

GPIO_UART_TX -- requirements
Module: gpio_uart_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/gpio_uart_tx_if.sv | 35 +++
 rtl/gpio_uart_tx_fifo.sv | 65 ++++++
 rtl/gpio_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM state encoding and serial line levels for gpio_uart_tx.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_IDLE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gpio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module : gpio_uart_tx_if
// Brief  : CPU-side capture inputs and UART/status outputs of gpio_uart_tx.
// Rev    : 1.0
// ============================================================================
interface gpio_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          en_i;
    logic [7:0]                    data_i;
    logic                          tx_o;
    logic                          busy_o;
    logic                          overflow_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;

    modport master (
        output en_i,
        output data_i,
        input  tx_o,
        input  busy_o,
        input  overflow_o,
        input  fifo_count_o
    );

    modport slave (
        input  en_i,
        input  data_i,
        output tx_o,
        output busy_o,
        output overflow_o,
        output fifo_count_o
    );
endinterface
`default_nettype wire

// File: rtl/gpio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : byte_fifo
// Brief  : Circular byte queue; a push into a full queue is accepted only
//          when a pop happens at the same edge.
// Rev    : 1.0
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [7:0]               din,
    output logic      [7:0]               dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int                    c_aw      = $clog2(DEPTH);
    localparam logic [c_aw-1:0]       c_ptr_max = c_aw'(DEPTH - 1);
    localparam logic [c_aw:0]         c_full    = (c_aw + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_max) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_max) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/gpio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : gpio_uart_tx
// Brief  : Captures changes of a CPU GPIO byte into a queue and sends each
//          byte as an 8N1 UART frame (8E1 when GPIO_UART_TX_PARITY_EN is set).
// Rev    : 1.0
// ============================================================================
module gpio_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    gpio_uart_tx_if.slave     bus
);
    localparam int                c_cw       = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0]   c_last_cnt = c_cw'(CLKS_PER_BIT - 1);
`ifdef GPIO_UART_TX_PARITY_EN
    localparam uart_state_e       c_after_data = ST_PARITY;
`else
    localparam uart_state_e       c_after_data = ST_STOP;
`endif

    uart_state_e                  r_state;
    logic [c_cw-1:0]              r_bit_cnt;
    logic [2:0]                   r_bit_idx;
    logic [7:0]                   r_shift;
    logic [7:0]                   r_prev_q;
    logic                         r_tx;
    logic                         r_overflow;

    logic                         w_push;
    logic                         w_pop;
    logic                         w_bit_end;
    logic                         w_full;
    logic                         w_empty;
    logic [7:0]                   w_fifo_dout;
    logic [$clog2(FIFO_DEPTH):0]  w_count;

    assign w_push    = bus.en_i && (bus.data_i != r_prev_q);
    assign w_bit_end = (r_bit_cnt == c_last_cnt);
    // Popping at the last STOP cycle chains frames without an idle gap.
    assign w_pop     = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.data_i),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_q   <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_prev_q <= bus.data_i;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (w_pop) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= w_fifo_dout;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= c_after_data;
                            r_bit_idx <= '0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef GPIO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= ST_STOP;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    // The line is a registered copy of the state, so it lags the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx <= LINE_IDLE;
        end else begin
            case (r_state)
                ST_START:  r_tx <= LINE_START;
                ST_DATA:   r_tx <= r_shift[r_bit_idx];
`ifdef GPIO_UART_TX_PARITY_EN
                ST_PARITY: r_tx <= ^r_shift;
`endif
                ST_STOP:   r_tx <= LINE_STOP;
                default:   r_tx <= LINE_IDLE;
            endcase
        end
    end

    assign bus.tx_o         = r_tx;
    assign bus.busy_o       = (r_state != ST_IDLE) || (w_count != '0);
    assign bus.overflow_o   = r_overflow;
    assign bus.fifo_count_o = w_count;
endmodule
`default_nettype wire

// File: tb/tb_gpio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_gpio_uart_tx
// Brief  : Directed and random stimulus against a queue/timeline model of
//          gpio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_gpio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef GPIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int LMAX  = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gpio_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    gpio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         e        = 0;
    int         fend     = 0;
    logic [7:0] q [$];
    logic [7:0] m_prev;
    logic       m_ovf;
    logic       line_exp [LMAX];

    // Line level for serial bit position k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef GPIO_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev = 8'h00;
        m_ovf  = 1'b0;
        fend   = e;
        for (int i = e; i < LMAX; i++) line_exp[i] = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model across the next edge, then check.
    task automatic cycle(input logic en, input logic [7:0] d);
        logic [7:0] b;
        bus.en_i   = en;
        bus.data_i = d;
        if (q.size() != 0 && e >= fend) begin
            b    = q.pop_front();
            fend = e + FRAME;
            for (int k = 0; k < FRAME; k++)
                if (e + 1 + k < LMAX) line_exp[e + 1 + k] = frame_bit(b, k / CPB);
        end
        if (en && d !== m_prev) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovf = 1'b1;
        end
        m_prev = d;
        @(posedge clk);
        #1;
        chk("tx_o",         32'(bus.tx_o),         32'(line_exp[e]));
        chk("busy_o",       32'(bus.busy_o),       32'((e < fend) || (q.size() != 0)));
        chk("fifo_count_o", 32'(bus.fifo_count_o), 32'(q.size()));
        chk("overflow_o",   32'(bus.overflow_o),   32'(m_ovf));
        e++;
    endtask

    initial begin
        logic [7:0] burst [6];
        logic [7:0] rd;
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bus.en_i   = 1'b0;
        bus.data_i = 8'h00;
        for (int i = 0; i < LMAX; i++) line_exp[i] = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_o",       32'(bus.tx_o),         32'd1);
        chk("rst_busy_o",     32'(bus.busy_o),       32'd0);
        chk("rst_overflow_o", 32'(bus.overflow_o),   32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count_o), 32'd0);
        reset = 1'b0;
        model_reset();

        // Changes while disabled, then enabled with a constant byte: no pushes.
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'(i * 37 + 1));
        repeat (5) cycle(1'b1, 8'h04);
        chk("no_push_count", 32'(bus.fifo_count_o), 32'd0);

        // Single frame 0xA5, then 0x01 (odd parity weight).
        cycle(1'b0, 8'h00);
        repeat (FRAME + 10) cycle(1'b1, 8'hA5);
        repeat (FRAME + 10) cycle(1'b1, 8'h01);
        chk("idle_busy_o", 32'(bus.busy_o), 32'd0);

        // Six bytes on consecutive edges: five fit, the last overflows.
        for (int i = 0; i < 6; i++) cycle(1'b1, burst[i]);
        chk("burst_overflow", 32'(bus.overflow_o), 32'd1);
        repeat (5 * FRAME + 10) cycle(1'b1, 8'h66);

        // Reset in the middle of a data bit with two bytes still queued.
        cycle(1'b1, 8'h80);
        cycle(1'b1, 8'h40);
        cycle(1'b1, 8'h20);
        repeat (12) cycle(1'b1, 8'h20);
        chk("pre_rst_count", 32'(bus.fifo_count_o), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_tx_o",   32'(bus.tx_o),         32'd1);
        chk("async_rst_count",  32'(bus.fifo_count_o), 32'd0);
        chk("async_rst_busy_o", 32'(bus.busy_o),       32'd0);
        chk("async_rst_ovf",    32'(bus.overflow_o),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (FRAME + 10) cycle(1'b1, 8'h3C);

        // Random enables and byte changes, including bursts that overflow.
        rd = 8'h3C;
        repeat (600) begin
            if ($urandom_range(0, 9) == 0) rd = 8'($urandom);
            cycle(logic'($urandom_range(0, 3) != 0), rd);
        end
        repeat (5 * FRAME) cycle(1'b0, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
